// File: rtl/matinv_seq.sv
// Sequencer and augmented [A|I] register file for a 5x5 Gauss-Jordan inverse, one element op per cycle.
// Define MATINV_SINGULAR_CHECK_EN to trap zero pivots into a sticky ERR state instead of dividing by zero.
module matinv_seq #(
   parameter int N = 5,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output logic         out_last_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(2 * N);
   localparam logic [RW-1:0] LAST_RC = RW'(N - 1);
   localparam logic [RW-1:0] R_ONE   = RW'(1);
   localparam logic [RW:0]   R1_ONE  = (RW + 1)'(1);
   localparam logic [RW:0]   NR1     = (RW + 1)'(N);
   localparam logic [CW-1:0] LAST_J  = CW'(2 * N - 1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] I_BASE  = CW'(N);

   typedef enum logic [2:0] {S_LOAD, S_PIV, S_NORM, S_FACT, S_ELIM, S_OUT, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  m_q [N][2*N];
   logic [RW-1:0] k_q, k_d, r_q, r_d, row_q, row_d, col_q, col_d;
   logic [CW-1:0] j_q, j_d;
   logic [W-1:0]  p_q, p_d, f_q, f_d;
   logic [RW:0]   r_nx;
   logic          in_ready_d, out_valid_d, out_last_d, busy_d, err_d;
   logic [W-1:0]  out_data_d;

   // Shared element unit: row k feeds both the divider (NORM) and the multiply-subtract (ELIM).
   logic [W-1:0] piv_el, quot, prod, diff;
   assign piv_el = m_q[k_q][j_q];
   assign quot   = (p_q == '0) ? '1 : piv_el / p_q;
   assign prod   = f_q * piv_el;
   assign diff   = m_q[r_q][j_q] - prod;

   always_ff @(posedge clk) begin
      if (!reset) begin
         case (state_q)
            S_LOAD: if (in_valid_i && in_ready_o) begin
               m_q[row_q][CW'(col_q)]          <= in_data_i;
               m_q[row_q][I_BASE + CW'(col_q)] <= (row_q == col_q) ? W'(1) : '0;
            end
            S_NORM:  m_q[k_q][j_q] <= quot;
            S_ELIM:  m_q[r_q][j_q] <= diff;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      j_d     = j_q;
      row_d   = row_q;
      col_d   = col_q;
      p_d     = p_q;
      f_d     = f_q;
      r_nx    = '0;
      case (state_q)
         S_LOAD: if (in_valid_i && in_ready_o) begin
            if (col_q == LAST_RC) begin
               col_d = '0;
               if (row_q == LAST_RC) begin
                  row_d   = '0;
                  k_d     = '0;
                  state_d = S_PIV;
               end else begin
                  row_d = row_q + R_ONE;
               end
            end else begin
               col_d = col_q + R_ONE;
            end
         end
         S_PIV: begin
            p_d     = m_q[k_q][CW'(k_q)];
            j_d     = '0;
            state_d = S_NORM;
`ifdef MATINV_SINGULAR_CHECK_EN
            if (m_q[k_q][CW'(k_q)] == '0) state_d = S_ERR;
`endif
         end
         S_NORM: if (j_q == LAST_J) begin
            j_d     = '0;
            r_d     = (k_q == '0) ? R_ONE : '0;
            state_d = S_FACT;
         end else begin
            j_d = j_q + C_ONE;
         end
         S_FACT: begin
            f_d     = m_q[r_q][CW'(k_q)];
            j_d     = '0;
            state_d = S_ELIM;
         end
         S_ELIM: if (j_q == LAST_J) begin
            j_d  = '0;
            // Next row to eliminate skips the pivot row itself.
            r_nx = {1'b0, r_q} + R1_ONE;
            if (r_nx == {1'b0, k_q}) r_nx = r_nx + R1_ONE;
            if (r_nx < NR1) begin
               r_d     = r_nx[RW-1:0];
               state_d = S_FACT;
            end else if (k_q == LAST_RC) begin
               row_d   = '0;
               col_d   = '0;
               state_d = S_OUT;
            end else begin
               k_d     = k_q + R_ONE;
               state_d = S_PIV;
            end
         end else begin
            j_d = j_q + C_ONE;
         end
         S_OUT: if (out_valid_o && out_ready_i) begin
            if (out_last_o) begin
               row_d   = '0;
               col_d   = '0;
               state_d = S_LOAD;
            end else if (col_q == LAST_RC) begin
               col_d = '0;
               row_d = row_q + R_ONE;
            end else begin
               col_d = col_q + R_ONE;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_LOAD;
      endcase

      // Outputs are registered from next-state so they line up with the state they describe.
      in_ready_d  = (state_d == S_LOAD);
      out_valid_d = (state_d == S_OUT);
      busy_d      = (state_d == S_PIV) || (state_d == S_NORM) || (state_d == S_FACT) || (state_d == S_ELIM);
      out_data_d  = (state_d == S_OUT) ? m_q[row_d][I_BASE + CW'(col_d)] : '0;
      out_last_d  = (state_d == S_OUT) && (row_d == LAST_RC) && (col_d == LAST_RC);
`ifdef MATINV_SINGULAR_CHECK_EN
      err_d       = (state_d == S_ERR);
`else
      err_d       = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         k_q         <= '0;
         r_q         <= '0;
         j_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         p_q         <= '0;
         f_q         <= '0;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         r_q         <= r_d;
         j_q         <= j_d;
         row_q       <= row_d;
         col_q       <= col_d;
         p_q         <= p_d;
         f_q         <= f_d;
         in_ready_o  <= in_ready_d;
         out_valid_o <= out_valid_d;
         out_data_o  <= out_data_d;
         out_last_o  <= out_last_d;
         busy_o      <= busy_d;
         err_o       <= err_d;
      end
   end

endmodule
